local_inject_arbiter: RTL and testbench
=======================================

# local_inject_arbiter

Round-robin scheduler that shares a node's single local injection port (router local rx: data, valid, busy) among up to `N_SRC` flit producers, such as the NI traffic source, a configuration writer and a loopback tester. Each requester gets a one-flit holding register. The block grants one held flit per cycle into a registered output stage that obeys the router's valid/busy handshake. It also counts forwarded flits and flags a stalled router port. It sits between the requesters and the router's local rx port.

## Interface
- `N_SRC`, default 4: number of requesters (2..8).
- `FLIT_W`, default 32: flit width, equal to HDR_SZ+PL_SZ+ADDR_SZ of the build.
- `STALL_MAX`, default 1023: consecutive blocked cycles before `stall` is raised.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `src_en` in N_SRC: per-requester enable; a disabled requester is never granted.
- `src_valid` in N_SRC: requester i offers `src_data[i]` this cycle.
- `src_data` in N_SRC*FLIT_W: requester i's flit occupies bits [i*FLIT_W +: FLIT_W].
- `src_busy` out N_SRC: requester i must not present a flit.
- `out_data` out FLIT_W: flit to the router's local rx port.
- `out_valid` out 1: `out_data` is valid.
- `out_busy` in 1: the router's local rx port is busy.
- `flit_count` out 20: total flits transferred to the router; wraps at 2^20.
- `stall` out 1: sticky flag; the output has been blocked for STALL_MAX cycles.

## Operation
- **Handshake (both sides):** a transfer happens at a clock edge where valid=1 and busy=0. Data must be stable while valid=1.
- **Holding registers:**
  - `hold_v[i]` and `hold_d[i]` hold one flit per requester.
  - `src_busy[i]` = `hold_v[i]`. It is registered and independent of `src_valid`.
  - A flit is accepted when `src_valid[i]` & !`hold_v[i]`. That edge sets `hold_v[i]` and loads `hold_d[i]`.
- **Output stage:** `out_valid` and `out_data` are registers.
  - The output is free when `out_valid`=0, or when `out_valid`=1 and `out_busy`=0 (it drains this edge).
- **Arbitration:** runs when the output is free and at least one requester i has `hold_v[i]` & `src_en[i]`.
  - Search starts at `ptr`+1 mod N_SRC and takes the first eligible i.
  - At that edge: `out_data` <= `hold_d[i]`, `out_valid` <= 1, `hold_v[i]` <= 0, `ptr` <= i.
  - If the output is free and nobody is eligible, `out_valid` <= 0.
- **Disabled requester:** clearing `src_en[i]` leaves a held flit in place with `src_busy[i]` high. The flit is granted after `src_en[i]` is set again. It is never dropped.
- **flit_count:** increments by 1 on each output transfer (`out_valid` & !`out_busy`). It wraps from 0xFFFFF to 0.
- **Stall counter:**
  - A 16-bit counter increments each cycle where `out_valid` & `out_busy`, saturating at STALL_MAX.
  - It clears on any cycle without that condition.
  - When it reaches STALL_MAX, `stall` <= 1. `stall` clears only on reset.
- **Reset (async, active-low):** all `hold_v`=0, `src_busy`=0, `out_valid`=0, `out_data`=0, `ptr`=N_SRC-1 (so requester 0 wins first), `flit_count`=0, stall counter=0, `stall`=0. A reset in mid-transfer discards all held and output flits.

## Timing
- **Latency:** a requester flit accepted at edge k is held after k and can drive `out_valid` after edge k+1. Minimum latency is 2 cycles.
- **Throughput:**
  - Aggregate: 1 flit per cycle while the router is not busy and at least one hold register is full.
  - Per requester: 1 flit per 2 cycles. A hold register cannot be refilled on the edge that grants it, because `src_busy` falls one cycle later.
- **Drain and reload:** output drain and a new grant happen on the same edge with no bubble.
- **Busy timing:** `out_busy` is sampled combinationally for free/drain. No combinational path exists from any input to `src_busy` or `out_valid`.

## Test plan
- **Single flit after reset:** after reset release, requester 0 presents 0xA5A5A5A5 for one cycle with `out_busy`=0. Expect `out_valid` 2 cycles later with that data for exactly one cycle, and `flit_count`=1.
- **All four requesters at once:** all four present one flit in the same cycle, data 0x10..0x13, `out_busy`=0. Expect output order 0x10, 0x11, 0x12, 0x13 on consecutive cycles, and `ptr`=3 at the end.
- **Backpressure:** hold `out_busy`=1 for 5 cycles while `out_valid`=1. Expect `out_data` stable, `src_busy` high for full holds, and no loss. After release, expect all flits delivered in round-robin order.
- **Disable and re-enable:** clear `src_en[2]` while requester 2 holds 0x22 and others stream. Expect 0x22 withheld and `src_busy[2]`=1. After `src_en[2]` is set, expect 0x22 delivered within N_SRC cycles.
- **Stall flag:** with STALL_MAX=8, hold `out_busy`=1 for 8 cycles with `out_valid`=1. Expect `stall`=1 after the 8th cycle, still 1 after `out_busy` drops, and 0 only after reset.
- **Counter wrap and reset mid-flight:** preload `flit_count` to 0xFFFFF via forced traffic, then send one flit. Expect `flit_count`=0. Assert `reset` asynchronously while `out_valid`=1. Expect all outputs to reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/local_inject_arbiter_if.sv
// local_inject_arbiter_if: requester-side and router-side handshake bundle.
// Latency: none, wires only.
// Backpressure: src_busy toward requesters, out_busy from the router.
interface local_inject_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int FLIT_W = 32
);
  logic [N_SRC-1:0]        src_en;
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC*FLIT_W-1:0] src_data;
  logic [N_SRC-1:0]        src_busy;
  logic [FLIT_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_busy;

  // Environment side: requesters plus the router's local rx port.
  modport master (
    output src_en, src_valid, src_data, out_busy,
    input  src_busy, out_data, out_valid
  );

  // Arbiter side.
  modport slave (
    input  src_en, src_valid, src_data, out_busy,
    output src_busy, out_data, out_valid
  );
endinterface

// File: rtl/local_inject_arbiter.sv
// local_inject_arbiter: round-robin merge of per-requester one-flit holding registers onto the router local rx port.
// Latency: 2 cycles from the requester accept edge to out_valid; 1 flit/cycle aggregate.
// Backpressure: out_busy freezes the output register; src_busy is high while a requester's holding register is full.
module local_inject_arbiter #(
  parameter int N_SRC     = 4,
  parameter int FLIT_W    = 32,
  parameter int STALL_MAX = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  local_inject_arbiter_if.slave        bus,
  output logic [19:0]                  flit_count,
  output logic                         stall
);

  localparam int PTR_W = $clog2(N_SRC);

  logic [N_SRC-1:0]  hold_v;
  logic [FLIT_W-1:0] hold_d [N_SRC];
  logic [PTR_W-1:0]  ptr;
  logic [N_SRC-1:0]  eligible;
  logic              out_v;
  logic [FLIT_W-1:0] out_d;
  logic              out_free;
  logic              gnt_vld;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  cand;
  logic              xfer;
  logic              blocked;
  logic [15:0]       stall_cnt;
  logic [15:0]       stall_cnt_nxt;
  logic [19:0]       flit_cnt;

  // src_busy comes straight from registers, so nothing combinational reaches it.
  assign bus.src_busy  = hold_v;
  assign bus.out_valid = out_v;
  assign bus.out_data  = out_d;
  assign flit_count    = flit_cnt;

  assign eligible = hold_v & bus.src_en;
  assign xfer     = out_v & ~bus.out_busy;
  assign blocked  = out_v & bus.out_busy;
  // The output register can take a new flit when empty or draining on this edge.
  assign out_free = ~out_v | ~bus.out_busy;

  // Round-robin search: first eligible requester starting just after the last winner.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_SRC);
      if (!gnt_vld && eligible[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Holding registers: release on grant, otherwise capture an offered flit when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_v <= '0;
      for (int i = 0; i < N_SRC; i++) hold_d[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (out_free && gnt_vld && gnt_idx == PTR_W'(i)) begin
          hold_v[i] <= 1'b0;
        end else if (bus.src_valid[i] && !hold_v[i]) begin
          hold_v[i] <= 1'b1;
          hold_d[i] <= bus.src_data[i*FLIT_W +: FLIT_W];
        end
      end
    end
  end

  // Output stage: load the winner when free, go idle when free with no winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v <= 1'b0;
      out_d <= '0;
      ptr   <= PTR_W'(N_SRC - 1);
    end else if (out_free) begin
      if (gnt_vld) begin
        out_v <= 1'b1;
        out_d <= hold_d[gnt_idx];
        ptr   <= gnt_idx;
      end else begin
        out_v <= 1'b0;
      end
    end
  end

  // Consecutive blocked cycles, saturating so a long stall cannot wrap back below the limit.
  always_comb begin
    stall_cnt_nxt = '0;
    if (blocked) begin
      stall_cnt_nxt = (stall_cnt >= 16'(STALL_MAX)) ? 16'(STALL_MAX) : stall_cnt + 16'd1;
    end
  end

  // Transfer counter and sticky stall flag; stall is raised on the edge the count hits the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_cnt  <= '0;
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else begin
      if (xfer) flit_cnt <= flit_cnt + 20'd1;
      stall_cnt <= stall_cnt_nxt;
      if (blocked && stall_cnt_nxt == 16'(STALL_MAX)) stall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_local_inject_arbiter.sv
// tb_local_inject_arbiter: directed stimulus with a queue scoreboard checked by a negedge monitor.
// Latency: n/a.
// Backpressure: the bench drives out_busy directly.
module tb_local_inject_arbiter;

  logic        clk;
  logic        reset;
  logic [19:0] flit_count;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];

  local_inject_arbiter_if #(.N_SRC(4), .FLIT_W(32)) bus ();

  local_inject_arbiter #(.N_SRC(4), .FLIT_W(32), .STALL_MAX(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .flit_count (flit_count),
    .stall      (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  // Scoreboard monitor: every transfer seen on the router port must match the next expected flit.
  always @(negedge clk) begin
    if (reset && bus.out_valid && !bus.out_busy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_unexpected: got flit 0x%0h expected no transfer", bus.out_data);
      end else begin
        chk("out_flit", bus.out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    bit seen;
    reset         = 1'b1;
    bus.src_en    = 4'hF;
    bus.src_valid = 4'h0;
    bus.src_data  = '0;
    bus.out_busy  = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_src_busy", 32'(bus.src_busy), 0);
    chk("rst_flit_count", 32'(flit_count), 0);
    chk("rst_stall", 32'(stall), 0);
    #19 reset = 1'b1;
    tick();

    // Single flit after reset: 2-cycle latency, one-cycle pulse.
    bus.src_valid = 4'b0001;
    bus.src_data  = {32'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
    exp_q.push_back(32'hA5A5A5A5);
    tick();
    bus.src_valid = 4'b0000;
    chk("t1_valid_k", 32'(bus.out_valid), 0);
    chk("t1_busy_k", 32'(bus.src_busy), 32'h1);
    tick();
    chk("t1_valid_k1", 32'(bus.out_valid), 1);
    chk("t1_data_k1", bus.out_data, 32'hA5A5A5A5);
    tick();
    chk("t1_valid_k2", 32'(bus.out_valid), 0);
    chk("t1_count", 32'(flit_count), 1);

    // All four at once from a fresh reset: 0,1,2,3 back to back.
    pulse_reset();
    tick();
    bus.src_valid = 4'b1111;
    bus.src_data  = {32'h13, 32'h12, 32'h11, 32'h10};
    for (int j = 0; j < 4; j++) exp_q.push_back(32'h10 + 32'(j));
    tick();
    bus.src_valid = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t2_valid", 32'(bus.out_valid), 1);
      chk("t2_data", bus.out_data, 32'h10 + 32'(j));
    end
    tick();
    chk("t2_idle", 32'(bus.out_valid), 0);
    chk("t2_ptr", 32'(dut.ptr), 3);
    chk("t2_count", 32'(flit_count), 4);

    // Backpressure: 5 blocked cycles, requester 0 refills while blocked.
    bus.out_busy  = 1'b1;
    bus.src_valid = 4'b1111;
    bus.src_data  = {32'h33, 32'h32, 32'h31, 32'h30};
    exp_q.push_back(32'h30);
    exp_q.push_back(32'h31);
    exp_q.push_back(32'h32);
    exp_q.push_back(32'h33);
    exp_q.push_back(32'h34);
    tick();
    bus.src_valid = 4'b0000;
    tick();
    chk("t3_busy_after_grant", 32'(bus.src_busy), 32'hE);
    bus.src_valid = 4'b0001;
    bus.src_data  = {32'h0, 32'h0, 32'h0, 32'h34};
    tick();
    bus.src_valid = 4'b0000;
    chk("t3_busy_full", 32'(bus.src_busy), 32'hF);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t3_data_stable", bus.out_data, 32'h30);
      chk("t3_valid_held", 32'(bus.out_valid), 1);
    end
    chk("t3_busy_held", 32'(bus.src_busy), 32'hF);
    chk("t3_no_stall", 32'(stall), 0);
    bus.out_busy = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    chk("t3_idle", 32'(bus.out_valid), 0);
    chk("t3_count", 32'(flit_count), 9);

    // Disable requester 2 while it holds 0x22; others still stream.
    bus.src_en    = 4'b1011;
    bus.src_valid = 4'b1111;
    bus.src_data  = {32'h43, 32'h22, 32'h41, 32'h40};
    exp_q.push_back(32'h41);
    exp_q.push_back(32'h43);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h22);
    tick();
    bus.src_valid = 4'b0000;
    for (int j = 0; j < 6; j++) tick();
    chk("t4_withheld", 32'(bus.out_valid), 0);
    chk("t4_busy2", 32'(bus.src_busy), 32'h4);
    bus.src_en = 4'b1111;
    seen = 1'b0;
    for (int j = 0; j < 4 && !seen; j++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("t4_released", 32'(seen), 1);
    chk("t4_data", bus.out_data, 32'h22);
    tick();
    tick();
    chk("t4_count", 32'(flit_count), 13);

    // Stall flag: raised on the 8th blocked cycle, sticky afterwards.
    bus.out_busy  = 1'b1;
    bus.src_valid = 4'b0001;
    bus.src_data  = {32'h0, 32'h0, 32'h0, 32'h50};
    exp_q.push_back(32'h50);
    tick();
    bus.src_valid = 4'b0000;
    tick();
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 7) chk("t5_stall_7", 32'(stall), 0);
      if (j == 8) chk("t5_stall_8", 32'(stall), 1);
    end
    bus.out_busy = 1'b0;
    tick();
    tick();
    chk("t5_stall_sticky", 32'(stall), 1);

    // Counter wrap.
    force dut.flit_cnt = 20'hFFFFF;
    #1;
    release dut.flit_cnt;
    #1;
    chk("t6_preload", 32'(flit_count), 32'hFFFFF);
    bus.src_valid = 4'b0010;
    bus.src_data  = {32'h0, 32'h0, 32'h60, 32'h0};
    exp_q.push_back(32'h60);
    tick();
    bus.src_valid = 4'b0000;
    tick();
    tick();
    chk("t6_wrap", 32'(flit_count), 0);

    // Asynchronous reset while a flit sits blocked in the output register.
    bus.src_valid = 4'b1100;
    bus.src_data  = {32'h62, 32'h61, 32'h0, 32'h0};
    exp_q.push_back(32'h61);
    tick();
    bus.src_valid = 4'b0000;
    tick();
    tick();
    bus.out_busy = 1'b1;
    chk("t7_pre_valid", 32'(bus.out_valid), 1);
    chk("t7_pre_data", bus.out_data, 32'h62);
    chk("t7_pre_count", 32'(flit_count), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(bus.out_valid), 0);
    chk("t7_rst_data", bus.out_data, 0);
    chk("t7_rst_src_busy", 32'(bus.src_busy), 0);
    chk("t7_rst_count", 32'(flit_count), 0);
    chk("t7_rst_stall", 32'(stall), 0);
    #3;
    reset = 1'b1;
    bus.out_busy = 1'b0;
    for (int j = 0; j < 3; j++) tick();
    chk("t7_discarded", 32'(bus.out_valid), 0);
    chk("t7_count_after", 32'(flit_count), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
